// File: rtl/half_duplex_seq.sv
// rtl/half_duplex_seq.sv - half-duplex read/write sequencer driving a bidirectional IO stage
// Accepts one request at a time, drives or listens on the bus, then idles for a turnaround gap.
module half_duplex_seq #(
    parameter int WIDTH    = 8,
    parameter int WR_CYC   = 2,
    parameter int RD_LAT   = 3,
    parameter int TURN_CYC = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_wr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             io_en,
    output logic [WIDTH-1:0] io_din,
    input  logic [WIDTH-1:0] io_dout,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             wr_done,
    output logic             busy
);

    if (WR_CYC < 1 || WR_CYC > 255) begin : g_bad_wr_cyc
        $error("WR_CYC must be in 1..255");
    end
    if (RD_LAT < 1 || RD_LAT > 255) begin : g_bad_rd_lat
        $error("RD_LAT must be in 1..255");
    end
    if (TURN_CYC < 1 || TURN_CYC > 255) begin : g_bad_turn_cyc
        $error("TURN_CYC must be in 1..255");
    end

    // Counters hold "cycles remaining minus one", so each phase ends on cnt == 0.
    localparam logic [7:0] WR_LOAD   = 8'(WR_CYC - 1);
    localparam logic [7:0] RD_LOAD   = 8'(RD_LAT - 1);
    localparam logic [7:0] TURN_LOAD = 8'(TURN_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WR,
        S_RD_WAIT,
        S_TURN
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               io_en_q, io_en_d;
    logic [WIDTH-1:0]   io_din_q, io_din_d;
    logic [WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               wr_done_q, wr_done_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        io_en_d     = io_en_q;
        io_din_d    = io_din_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_valid_d = 1'b0;
        wr_done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                io_en_d = 1'b1;
                if (req_valid) begin
                    if (req_wr) begin
                        io_din_d = req_wdata;
                        io_en_d  = 1'b0;
                        cnt_d    = WR_LOAD;
                        state_d  = S_WR;
                    end else begin
                        cnt_d   = RD_LOAD;
                        state_d = S_RD_WAIT;
                    end
                end
            end
            S_WR: begin
                if (cnt_q == 8'd0) begin
                    io_en_d   = 1'b1;
                    wr_done_d = 1'b1;
                    cnt_d     = TURN_LOAD;
                    state_d   = S_TURN;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_RD_WAIT: begin
                if (cnt_q == 8'd0) begin
                    rsp_rdata_d = io_dout;
                    rsp_valid_d = 1'b1;
                    cnt_d       = TURN_LOAD;
                    state_d     = S_TURN;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_TURN: begin
                io_en_d = 1'b1;
                if (cnt_q == 8'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                io_en_d = 1'b1;
                cnt_d   = 8'd0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            io_en_q     <= 1'b1;
            io_din_q    <= '0;
            rsp_rdata_q <= '0;
            rsp_valid_q <= 1'b0;
            wr_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            io_en_q     <= io_en_d;
            io_din_q    <= io_din_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_valid_q <= rsp_valid_d;
            wr_done_q   <= wr_done_d;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign io_en     = io_en_q;
    assign io_din    = io_din_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_valid = rsp_valid_q;
    assign wr_done   = wr_done_q;

endmodule

// File: tb/tb_half_duplex_seq.sv
// tb/tb_half_duplex_seq.sv - self-checking bench for half_duplex_seq
// Instance 0 uses the default timing, instance 1 the 1/1/1 corner.
module tb_half_duplex_seq;

    localparam int WR0 = 2, RD0 = 3, TC0 = 1;
    localparam int WR1 = 1, RD1 = 1, TC1 = 1;

    logic       clk;
    logic       rst;
    logic       req_valid [2];
    logic       req_ready [2];
    logic       req_wr    [2];
    logic [7:0] req_wdata [2];
    logic       io_en     [2];
    logic [7:0] io_din    [2];
    logic [7:0] io_dout   [2];
    logic       rsp_valid [2];
    logic [7:0] rsp_rdata [2];
    logic       wr_done   [2];
    logic       busy      [2];

    int n_cmp = 0;
    int n_bad = 0;

    half_duplex_seq #(.WIDTH(8), .WR_CYC(WR0), .RD_LAT(RD0), .TURN_CYC(TC0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wr(req_wr[0]),
        .req_wdata(req_wdata[0]), .io_en(io_en[0]), .io_din(io_din[0]),
        .io_dout(io_dout[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
        .wr_done(wr_done[0]), .busy(busy[0])
    );

    half_duplex_seq #(.WIDTH(8), .WR_CYC(WR1), .RD_LAT(RD1), .TURN_CYC(TC1)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wr(req_wr[1]),
        .req_wdata(req_wdata[1]), .io_en(io_en[1]), .io_din(io_din[1]),
        .io_dout(io_dout[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
        .wr_done(wr_done[1]), .busy(busy[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %0h, required %0h", name, i, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Model: each transaction is a timeline of offsets since acceptance (0 = idle).
    int         m_off   [2] = '{0, 0};
    logic       m_wr    [2] = '{1'b0, 1'b0};
    logic [7:0] m_din   [2] = '{8'h00, 8'h00};
    logic [7:0] m_rdata [2] = '{8'h00, 8'h00};

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                int   wc, rl, tc, k, tot;
                logic e_en, e_done, e_rv;
                wc = (i == 0) ? WR0 : WR1;
                rl = (i == 0) ? RD0 : RD1;
                tc = (i == 0) ? TC0 : TC1;
                if (rst) begin
                    m_off[i]   = 0;
                    m_din[i]   = 8'h00;
                    m_rdata[i] = 8'h00;
                end
                k      = m_off[i];
                e_en   = 1'b1;
                e_done = 1'b0;
                e_rv   = 1'b0;
                if (k != 0) begin
                    if (m_wr[i]) begin
                        e_en   = (k > wc);
                        e_done = (k == wc + 1);
                    end else begin
                        e_rv = (k == rl + 1);
                    end
                end
                chk("m_io_en",     i, io_en[i],     e_en);
                chk("m_io_din",    i, io_din[i],    m_din[i]);
                chk("m_wr_done",   i, wr_done[i],   e_done);
                chk("m_rsp_valid", i, rsp_valid[i], e_rv);
                chk("m_rsp_rdata", i, rsp_rdata[i], m_rdata[i]);
                chk("m_req_ready", i, req_ready[i], k == 0);
                chk("m_busy",      i, busy[i],      k != 0);
                if (!rst) begin
                    if (k != 0 && !m_wr[i] && k == rl) m_rdata[i] = io_dout[i];
                    tot = m_wr[i] ? wc + tc : rl + tc;
                    if (k == 0) begin
                        if (req_valid[i]) begin
                            m_off[i] = 1;
                            m_wr[i]  = req_wr[i];
                            if (req_wr[i]) m_din[i] = req_wdata[i];
                        end
                    end else if (k == tot) begin
                        m_off[i] = 0;
                    end else begin
                        m_off[i] = k + 1;
                    end
                end
            end
        end
    end

    initial begin
        int cnt;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            req_wr[i]    = 1'b0;
            req_wdata[i] = 8'h00;
            io_dout[i]   = 8'h00;
        end
        repeat (3) cyc();
        chk("rst_io_en", 0, io_en[0], 1'b1);
        chk("rst_io_din", 0, io_din[0], 8'h00);
        chk("rst_rdata", 0, rsp_rdata[0], 8'h00);
        rst = 1'b0;
        cyc();
        cyc();
        chk("rel_ready", 0, req_ready[0], 1'b1);

        // Single write of 0xA5
        req_valid[0] = 1'b1; req_wr[0] = 1'b1; req_wdata[0] = 8'hA5;
        cyc();
        req_valid[0] = 1'b0;
        chk("w_c1_io_en", 0, io_en[0], 1'b0);
        chk("w_c1_din", 0, io_din[0], 8'hA5);
        cyc();
        chk("w_c2_io_en", 0, io_en[0], 1'b0);
        chk("w_c2_din", 0, io_din[0], 8'hA5);
        cyc();
        chk("w_c3_io_en", 0, io_en[0], 1'b1);
        chk("w_c3_done", 0, wr_done[0], 1'b1);
        chk("w_c3_ready", 0, req_ready[0], 1'b0);
        cyc();
        chk("w_c4_ready", 0, req_ready[0], 1'b1);
        chk("w_c4_done", 0, wr_done[0], 1'b0);

        // Single read, bus shows 0x3C from cycle 1
        req_valid[0] = 1'b1; req_wr[0] = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            cyc();
            if (c == 1) begin
                req_valid[0] = 1'b0;
                io_dout[0]   = 8'h3C;
            end
            chk("r_listen_io_en", 0, io_en[0], 1'b1);
            chk("r_listen_ready", 0, req_ready[0], 1'b0);
        end
        cyc();
        chk("r_c4_valid", 0, rsp_valid[0], 1'b1);
        chk("r_c4_rdata", 0, rsp_rdata[0], 8'h3C);
        cyc();
        chk("r_c5_ready", 0, req_ready[0], 1'b1);
        io_dout[0] = 8'h00;
        repeat (3) cyc();
        chk("r_hold_rdata", 0, rsp_rdata[0], 8'h3C);

        // Back-to-back: write 0x11, read 0x77, write 0x22 with req_valid held
        req_valid[0] = 1'b1; req_wr[0] = 1'b1; req_wdata[0] = 8'h11;
        cyc();
        req_wr[0] = 1'b0; req_wdata[0] = 8'hEE; io_dout[0] = 8'h77;
        cyc();
        chk("b_c2_din", 0, io_din[0], 8'h11);
        cyc();
        cyc();
        chk("b_c4_ready", 0, req_ready[0], 1'b1);
        cyc();
        chk("b_c5_ready", 0, req_ready[0], 1'b0);
        req_wr[0] = 1'b1; req_wdata[0] = 8'h22;
        repeat (3) cyc();
        chk("b_c8_valid", 0, rsp_valid[0], 1'b1);
        chk("b_c8_rdata", 0, rsp_rdata[0], 8'h77);
        cyc();
        chk("b_c9_ready", 0, req_ready[0], 1'b1);
        cyc();
        req_valid[0] = 1'b0;
        chk("b_c10_io_en", 0, io_en[0], 1'b0);
        chk("b_c10_din", 0, io_din[0], 8'h22);
        cyc();
        chk("b_c11_io_en", 0, io_en[0], 1'b0);
        chk("b_c11_din", 0, io_din[0], 8'h22);
        cyc();
        chk("b_c12_done", 0, wr_done[0], 1'b1);
        cyc();
        chk("b_c13_ready", 0, req_ready[0], 1'b1);

        // Request pulsed while busy is dropped
        req_valid[0] = 1'b1; req_wr[0] = 1'b1; req_wdata[0] = 8'hAA;
        cyc();
        req_valid[0] = 1'b0;
        cyc();
        req_valid[0] = 1'b1; req_wdata[0] = 8'hFF;
        chk("busy_c2_din", 0, io_din[0], 8'hAA);
        cyc();
        req_valid[0] = 1'b0;
        chk("busy_c3_done", 0, wr_done[0], 1'b1);
        cnt = 0;
        for (int c = 0; c < 4; c++) begin
            cyc();
            cnt += int'(wr_done[0]);
        end
        chk("busy_extra_done", 0, cnt, 0);
        chk("busy_din_kept", 0, io_din[0], 8'hAA);
        chk("busy_idle", 0, busy[0], 1'b0);

        // Asynchronous reset in the middle of a write
        req_valid[0] = 1'b1; req_wr[0] = 1'b1; req_wdata[0] = 8'h5A;
        cyc();
        req_valid[0] = 1'b0;
        chk("rw_pre_io_en", 0, io_en[0], 1'b0);
        #1 rst = 1'b1;
        #1;
        chk("rw_async_io_en", 0, io_en[0], 1'b1);
        chk("rw_async_din", 0, io_din[0], 8'h00);
        chk("rw_async_busy", 0, busy[0], 1'b0);
        cyc();
        rst = 1'b0;
        cnt = 0;
        for (int c = 0; c < 4; c++) begin
            cyc();
            cnt += int'(wr_done[0]);
        end
        chk("rw_no_done", 0, cnt, 0);
        chk("rw_ready", 0, req_ready[0], 1'b1);

        // Corner instance: alternating write/read, one request every 3 cycles
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            if (c % 3 == 0) begin
                req_valid[1] = 1'b1;
                req_wr[1]    = ((c / 3) % 2 == 0);
                req_wdata[1] = 8'h80 + 8'(c);
            end
            io_dout[1] = 8'hC0 ^ 8'(c);
            chk("alt_ready", 1, req_ready[1], (c % 3) == 0);
            cnt += int'(!io_en[1]);
            if (c == 2) chk("alt_c2_done", 1, wr_done[1], 1'b1);
            if (c == 5) chk("alt_c5_valid", 1, rsp_valid[1], 1'b1);
            if (c == 5) chk("alt_c5_rdata", 1, rsp_rdata[1], 8'hC4);
            if (c == 7) chk("alt_c7_din", 1, io_din[1], 8'h86);
            cyc();
        end
        req_valid[1] = 1'b0;
        chk("alt_drive_cycles", 1, cnt, 2);
        repeat (4) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
